// File: rtl/fp_int_mul_bit_serial_mc.sv
// Multi-lane FP x signed-INT bit-serial multiplier with shared bit counter and runtime precision.
// Optional NORM_EN macro adds a registered leading-zero normaliser stage on the outputs.
module fp_int_mul_bit_serial_mc #(
    parameter int LANES     = 4,
    parameter int ACT_WIDTH = 16,
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 10,
    parameter int MAX_PREC  = 8,
    localparam int PW  = $clog2(MAX_PREC + 1),
    localparam int OMW = MAN_WIDTH + MAX_PREC,
    localparam int OEW = EXP_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*ACT_WIDTH-1:0] act,
    input  logic [LANES-1:0]           w,
    input  logic                       valid,
    input  logic                       set,
    input  logic [PW-1:0]              precision,
    output logic [LANES-1:0]           sign_out,
    output logic [LANES*OEW-1:0]       exp_out,
    output logic [LANES*OMW-1:0]       mantissa_out,
    output logic                       start_acc,
    output logic                       busy
);
    localparam int SW = MAN_WIDTH + 1;
    localparam int AW = OMW + 1;
    localparam logic [PW-1:0] PMAX = PW'(MAX_PREC);
    localparam logic [PW-1:0] PMIN = PW'(2);

    logic [PW-1:0]                prec_q, prec_d, cnt_q, cnt_d;
    logic                         consume, lastBit;
    logic [ACT_WIDTH-1:0]         actLane [LANES];
    logic [LANES-1:0]             sign_q, sign_d, resNeg;
    logic [EXP_WIDTH-1:0]         exp_q [LANES];
    logic [EXP_WIDTH-1:0]         exp_d [LANES];
    logic [SW-1:0]                sig_q [LANES];
    logic [SW-1:0]                sig_d [LANES];
    logic [SW-1:0]                opSig [LANES];
    logic signed [AW-1:0]         acc_q [LANES];
    logic signed [AW-1:0]         acc_d [LANES];
    logic signed [AW-1:0]         term  [LANES];
    logic [OMW-1:0]               resMag [LANES];

    logic [LANES-1:0]             rawSign_q;
    logic [EXP_WIDTH-1:0]         rawExp_q [LANES];
    logic [OMW-1:0]               rawMag_q [LANES];
    logic                         rawStart_q;

    always_comb begin
        consume = valid && !set;
        lastBit = consume && (cnt_q == prec_q - PW'(1));
        prec_d  = prec_q;
        cnt_d   = cnt_q;
        if (set) begin
            if (precision < PMIN)      prec_d = PMIN;
            else if (precision > PMAX) prec_d = PMAX;
            else                       prec_d = precision;
            cnt_d = '0;
        end else if (consume) begin
            cnt_d = lastBit ? '0 : cnt_q + PW'(1);
        end
    end

    // Bit 0 latches the operands and loads the accumulator; the top weight bit carries negative weight.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            actLane[l] = act[l*ACT_WIDTH +: ACT_WIDTH];
            sign_d[l]  = sign_q[l];
            exp_d[l]   = exp_q[l];
            sig_d[l]   = sig_q[l];
            acc_d[l]   = acc_q[l];
            opSig[l]   = sig_q[l];
            term[l]    = '0;
            if (set) begin
                acc_d[l] = '0;
            end else if (consume) begin
                if (cnt_q == '0) begin
                    sign_d[l] = actLane[l][ACT_WIDTH-1];
                    exp_d[l]  = actLane[l][ACT_WIDTH-2 -: EXP_WIDTH];
                    sig_d[l]  = {(actLane[l][ACT_WIDTH-2 -: EXP_WIDTH] != '0),
                                 actLane[l][MAN_WIDTH-1:0]};
                    opSig[l]  = sig_d[l];
                end
                term[l] = w[l] ? (AW'(opSig[l]) << cnt_q) : '0;
                if (cnt_q == '0)  acc_d[l] = term[l];
                else if (lastBit) acc_d[l] = acc_q[l] - term[l];
                else              acc_d[l] = acc_q[l] + term[l];
            end
            resNeg[l] = acc_d[l][AW-1];
            resMag[l] = resNeg[l] ? OMW'(-acc_d[l]) : OMW'(acc_d[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prec_q     <= PMAX;
            cnt_q      <= '0;
            sign_q     <= '0;
            rawSign_q  <= '0;
            rawStart_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                exp_q[l]    <= '0;
                sig_q[l]    <= '0;
                acc_q[l]    <= '0;
                rawExp_q[l] <= '0;
                rawMag_q[l] <= '0;
            end
        end else begin
            prec_q     <= prec_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            rawStart_q <= lastBit;
            for (int l = 0; l < LANES; l++) begin
                exp_q[l] <= exp_d[l];
                sig_q[l] <= sig_d[l];
                acc_q[l] <= acc_d[l];
            end
            if (lastBit) begin
                rawSign_q <= sign_q ^ resNeg;
                for (int l = 0; l < LANES; l++) begin
                    rawExp_q[l] <= exp_q[l];
                    rawMag_q[l] <= resMag[l];
                end
            end
        end
    end

`ifdef NORM_EN
    logic [LANES-1:0] outSign_q;
    logic [OEW-1:0]   outExp_q [LANES];
    logic [OMW-1:0]   outMag_q [LANES];
    logic             outStart_q;
    logic [OEW-1:0]   normExp [LANES];
    logic [OMW-1:0]   normMag [LANES];
    int               lz [LANES];
    int               lim [LANES];
    int               sh [LANES];

    // Shift out leading zeros, but never drive the exponent below zero.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lz[l] = OMW;
            for (int b = 0; b < OMW; b++) begin
                if (rawMag_q[l][b]) lz[l] = OMW - 1 - b;
            end
            lim[l] = int'(rawExp_q[l]) + MAX_PREC - 1;
            sh[l]  = (lz[l] < lim[l]) ? lz[l] : lim[l];
            if (rawMag_q[l] == '0) begin
                normMag[l] = '0;
                normExp[l] = '0;
            end else begin
                normMag[l] = rawMag_q[l] << sh[l];
                normExp[l] = OEW'(lim[l] - sh[l]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outSign_q  <= '0;
            outStart_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                outExp_q[l] <= '0;
                outMag_q[l] <= '0;
            end
        end else begin
            outStart_q <= rawStart_q;
            if (rawStart_q) begin
                outSign_q <= rawSign_q;
                for (int l = 0; l < LANES; l++) begin
                    outExp_q[l] <= normExp[l];
                    outMag_q[l] <= normMag[l];
                end
            end
        end
    end

    always_comb begin
        sign_out = outSign_q;
        for (int l = 0; l < LANES; l++) begin
            exp_out[l*OEW +: OEW]      = outExp_q[l];
            mantissa_out[l*OMW +: OMW] = outMag_q[l];
        end
    end
    assign start_acc = outStart_q;
`else
    always_comb begin
        sign_out = rawSign_q;
        for (int l = 0; l < LANES; l++) begin
            exp_out[l*OEW +: OEW]      = {1'b0, rawExp_q[l]};
            mantissa_out[l*OMW +: OMW] = rawMag_q[l];
        end
    end
    assign start_acc = rawStart_q;
`endif

    assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_fp_int_mul_bit_serial_mc.sv
// Scoreboard bench for fp_int_mul_bit_serial_mc (4 lanes, MAX_PREC=4); honours NORM_EN if defined.
module tb_fp_int_mul_bit_serial_mc;
    localparam int LANES    = 4;
    localparam int MAX_PREC = 4;
    localparam int PW       = 3;
    localparam int OMW      = 14;
    localparam int OEW      = 6;
`ifdef NORM_EN
    localparam int LAT = 2;
    localparam bit NORM = 1'b1;
`else
    localparam int LAT = 1;
    localparam bit NORM = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [LANES*16-1:0]    act = '0;
    logic [LANES-1:0]       w = '0;
    logic                   valid = 1'b0;
    logic                   set = 1'b0;
    logic [PW-1:0]          precision = '0;
    logic [LANES-1:0]       sign_out;
    logic [LANES*OEW-1:0]   exp_out;
    logic [LANES*OMW-1:0]   mantissa_out;
    logic                   start_acc;
    logic                   busy;

    fp_int_mul_bit_serial_mc #(.LANES(LANES), .MAX_PREC(MAX_PREC)) dut (
        .clk(clk), .rst(rst), .act(act), .w(w), .valid(valid), .set(set),
        .precision(precision), .sign_out(sign_out), .exp_out(exp_out),
        .mantissa_out(mantissa_out), .start_acc(start_acc), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   cyc;
        logic [LANES-1:0]     s;
        logic [LANES*OEW-1:0] e;
        logic [LANES*OMW-1:0] m;
    } exp_t;

    exp_t sb[$];
    exp_t mon;
    exp_t lastRes;
    int   cyc = 0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every start_acc pulse must match the oldest pending expectation in value and timing.
    always @(negedge clk) begin
        if (start_acc === 1'b1) begin
            testsRun++;
            if (sb.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_start_acc at cycle %0d", cyc);
            end else begin
                mon = sb.pop_front();
                if (cyc !== mon.cyc) begin
                    testsFailed++;
                    $display("[TB] FAIL start_latency got cycle %0d want %0d", cyc, mon.cyc);
                end
                testsRun++;
                if ({sign_out, exp_out, mantissa_out} !== {mon.s, mon.e, mon.m}) begin
                    testsFailed++;
                    $display("[TB] FAIL result got s=%h e=%h m=%h want s=%h e=%h m=%h",
                             sign_out, exp_out, mantissa_out, mon.s, mon.e, mon.m);
                end
                lastRes = mon;
            end
        end
    end

    function automatic exp_t model(input logic [LANES*16-1:0] a, input logic [LANES*8-1:0] wts,
                                   input int prec);
        exp_t r;
        r.cyc = 0;
        r.s = '0;
        r.e = '0;
        r.m = '0;
        for (int l = 0; l < LANES; l++) begin
            logic [15:0] av;
            int ex, sig, wv, p, mag, e, m, lz, lim, sh;
            av  = a[l*16 +: 16];
            ex  = int'(av[14:10]);
            sig = (ex != 0) ? 1024 + int'(av[9:0]) : int'(av[9:0]);
            wv  = int'(wts[l*8 +: 8]) & ((1 << prec) - 1);
            if (wv >= (1 << (prec - 1))) wv = wv - (1 << prec);
            p   = sig * wv;
            mag = (p < 0) ? -p : p;
            r.s[l] = av[15] ^ (p < 0);
            e = ex;
            m = mag;
            if (NORM) begin
                if (mag == 0) begin
                    e = 0;
                    m = 0;
                end else begin
                    lz = 0;
                    while (lz < OMW && ((mag >> (OMW - 1 - lz)) & 1) == 0) lz++;
                    lim = ex + MAX_PREC - 1;
                    sh  = (lz < lim) ? lz : lim;
                    m   = mag << sh;
                    e   = lim - sh;
                end
            end
            r.e[l*OEW +: OEW] = OEW'(e);
            r.m[l*OMW +: OMW] = OMW'(m);
        end
        return r;
    endfunction

    task automatic runOp(input logic [LANES*16-1:0] a, input logic [LANES*8-1:0] wts,
                         input int prec, input int nBits, input int stallAt, input int stallLen,
                         input bit scramble, input bit endIdle);
        exp_t e;
        e = model(a, wts, prec);
        for (int k = 0; k < nBits; k++) begin
            @(negedge clk);
            if (k == stallAt) begin
                valid = 1'b0;
                repeat (stallLen) @(negedge clk);
            end
            testsRun++;
            if (busy !== (k != 0)) begin
                testsFailed++;
                $display("[TB] FAIL busy_bit%0d got %b want %b", k, busy, (k != 0));
            end
            valid = 1'b1;
            set   = 1'b0;
            for (int l = 0; l < LANES; l++) w[l] = wts[l*8 + k];
            act = (k == 0 || !scramble) ? a : {LANES{16'hF234}};
            if (k == prec - 1 && nBits == prec) begin
                e.cyc = cyc + LAT;
                sb.push_back(e);
            end
        end
        if (endIdle) begin
            @(negedge clk);
            valid = 1'b0;
            w     = '0;
        end
    endtask

    task automatic doSet(input logic [PW-1:0] p);
        @(negedge clk);
        set       = 1'b1;
        valid     = 1'b1;
        w         = '1;
        precision = p;
        @(negedge clk);
        set   = 1'b0;
        valid = 1'b0;
        w     = '0;
    endtask

    task automatic checkZero(input string tag);
        testsRun++;
        if ({sign_out, exp_out, mantissa_out, start_acc, busy} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL %s got s=%h e=%h m=%h start=%b busy=%b want all 0",
                     tag, sign_out, exp_out, mantissa_out, start_acc, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checkZero("reset_outputs");
        rst = 1'b0;
        // No set: the reset precision must be MAX_PREC.
        runOp({16'h4000, 16'hC500, 16'h0000, 16'h3C00}, {8'd7, 8'd5, 8'd9, 8'd3}, 4, 4, -1, 0, 0, 1);
    endtask

    task automatic test_basic();
        runOp({16'h4000, 16'hC500, 16'h0000, 16'h3C00}, {8'd7, 8'd5, 8'd9, 8'd3}, 4, 4, -1, 0, 0, 1);
        repeat (LAT) @(negedge clk);
        testsRun++;
        if (mantissa_out[13:0] !== (NORM ? 14'h3000 : 14'h0C00) ||
            exp_out[5:0] !== (NORM ? 6'd16 : 6'd15) || sign_out[0] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL case1_lane0 got s=%b e=%0d m=%h", sign_out[0], exp_out[5:0],
                     mantissa_out[13:0]);
        end
        runOp({16'h7C00, 16'h8001, 16'h3FFF, 16'hBC00}, {8'd1, 8'd6, 8'd8, 8'hFE}, 4, 4, -1, 0, 0, 1);
        repeat (LAT) @(negedge clk);
        if (!NORM) begin
            testsRun++;
            if (mantissa_out[13:0] !== 14'd2048 || mantissa_out[27:14] !== 14'd16376 ||
                sign_out[1:0] !== 2'b10) begin
                testsFailed++;
                $display("[TB] FAIL case2 got s=%b m0=%0d m1=%0d want s=10 m0=2048 m1=16376",
                         sign_out[1:0], mantissa_out[13:0], mantissa_out[27:14]);
            end
        end
    endtask

    task automatic test_precision();
        doSet(3'd2);
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL set_busy got %b want 0", busy);
        end
        runOp({16'h0000, 16'h0000, 16'h0000, 16'h3C00}, {8'd1, 8'd3, 8'd0, 8'd2}, 2, 2, -1, 0, 0, 1);
        repeat (LAT) @(negedge clk);
        testsRun++;
        if (sign_out[0] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL prec2_sign got %b want 1", sign_out[0]);
        end
        doSet(3'd0);
        runOp({16'h4400, 16'hB800, 16'h3555, 16'h3C00}, {8'd1, 8'd2, 8'd3, 8'd2}, 2, 2, -1, 0, 0, 1);
        doSet(3'd7);
        runOp({16'h4400, 16'hB800, 16'h3555, 16'h3C00}, {8'd9, 8'd12, 8'd5, 8'd15}, 4, 4, -1, 0, 0, 1);
    endtask

    task automatic test_stall();
        runOp({16'h4000, 16'hC500, 16'h0000, 16'h3C00}, {8'd7, 8'd5, 8'd9, 8'd3}, 4, 4, 2, 3, 1, 1);
    endtask

    task automatic test_back_to_back();
        runOp({16'h1234, 16'hABCD, 16'h5678, 16'h3C00}, {8'd10, 8'd4, 8'd13, 8'd3}, 4, 4, -1, 0, 0, 0);
        runOp({16'h4321, 16'hDCBA, 16'h0400, 16'hBC00}, {8'd8, 8'd7, 8'd1, 8'd14}, 4, 4, -1, 0, 0, 0);
        runOp({16'h7BFF, 16'h03FF, 16'h8000, 16'h3FFF}, {8'd15, 8'd8, 8'd6, 8'd8}, 4, 4, -1, 0, 0, 1);
    endtask

    task automatic test_abort();
        runOp({16'h4000, 16'hC500, 16'h1111, 16'h3C00}, {8'd7, 8'd5, 8'd9, 8'd3}, 4, 3, -1, 0, 0, 0);
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        checkZero("midop_reset");
        rst = 1'b0;
        runOp({16'h4000, 16'hC500, 16'h1111, 16'h3C00}, {8'd7, 8'd5, 8'd9, 8'd3}, 4, 4, -1, 0, 0, 1);
        runOp({16'h4000, 16'hC500, 16'h1111, 16'h3C00}, {8'd7, 8'd5, 8'd9, 8'd3}, 4, 2, -1, 0, 0, 0);
        doSet(3'd2);
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_busy got %b want 0", busy);
        end
        runOp({16'h0000, 16'h0000, 16'h0000, 16'h3C00}, {8'd1, 8'd3, 8'd0, 8'd2}, 2, 2, -1, 0, 0, 1);
        doSet(3'd4);
        runOp({16'h0000, 16'h8001, 16'h0200, 16'h0001}, {8'd3, 8'd4, 8'd7, 8'd5}, 4, 4, -1, 0, 0, 1);
        repeat (LAT) @(negedge clk);
        testsRun++;
        if (exp_out[5:0] !== 6'd0 || mantissa_out[13:0] !== (NORM ? 14'd40 : 14'd5)) begin
            testsFailed++;
            $display("[TB] FAIL subnormal got e=%0d m=%0d", exp_out[5:0], mantissa_out[13:0]);
        end
    endtask

    task automatic test_hold();
        repeat (6) @(negedge clk);
        testsRun++;
        if ({sign_out, exp_out, mantissa_out} !== {lastRes.s, lastRes.e, lastRes.m}) begin
            testsFailed++;
            $display("[TB] FAIL hold got s=%h e=%h m=%h want s=%h e=%h m=%h", sign_out, exp_out,
                     mantissa_out, lastRes.s, lastRes.e, lastRes.m);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_precision();
        test_stall();
        test_back_to_back();
        test_abort();
        test_hold();
        repeat (LAT + 2) @(negedge clk);
        testsRun++;
        if (sb.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL pending_results got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
